// File: rtl/sdram_rd_prefetch.sv
// Read-ahead feeder for the SPI SDRAM read-out slave: fetches words from a wrapping
// address window into a small FIFO and hands one out per rising edge of rd_req.
module sdram_rd_prefetch #(
    parameter int Nbit  = 8,
    parameter int AW    = 22,
    parameter int DEPTH = 4,
    parameter int TMO   = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    addr_load,
    input  logic [AW-1:0]           addr_start,
    input  logic [AW-1:0]           addr_end,
    input  logic                    rd_req,
    output logic                    rd_ok,
    output logic [Nbit-1:0]         data_out,
    output logic                    sd_rd,
    output logic [AW-1:0]           sd_adr,
    input  logic                    sd_ack,
    input  logic                    sd_dv,
    input  logic [Nbit-1:0]         sd_data,
    output logic [$clog2(DEPTH):0]  fifo_cnt,
    output logic                    err_tmo
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (TMO < 1) ? 1 : $clog2(TMO + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_en;
    logic            r_discard, w_discard_nxt;
    logic            w_push, w_advance, w_tmo_hit, w_pop, w_rd_edge;
    logic [TW-1:0]   r_tmo_cnt;
    logic            r_err_tmo;
    logic [AW-1:0]   r_cur_adr, r_start, r_end;
    logic [Nbit-1:0] r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_fifo_cnt;
    logic            r_rd_req_d, r_pop_pend, r_rd_ok;
    logic [Nbit-1:0] r_data_out;

    function automatic logic [AW-1:0] next_adr(input logic [AW-1:0] cur,
                                               input logic [AW-1:0] first,
                                               input logic [AW-1:0] last);
        return (cur == last) ? first : cur + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_discard <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_discard <= w_discard_nxt;
        end
    end

    // One read outstanding at most, so "inflight" is simply "not IDLE".
    always_comb begin
        w_state_nxt   = r_state;
        w_discard_nxt = r_discard;
        w_push        = 1'b0;
        w_advance     = 1'b0;
        w_tmo_hit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_en && !addr_load && (r_fifo_cnt < CW'(DEPTH)))
                    w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (sd_ack) begin
                    w_state_nxt = S_WAIT;
                    if (addr_load)
                        w_discard_nxt = 1'b1;
                end else if (addr_load) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (sd_dv) begin
                    w_state_nxt   = S_IDLE;
                    w_discard_nxt = 1'b0;
                    if (!r_discard && !addr_load) begin
                        w_push    = 1'b1;
                        w_advance = 1'b1;
                    end
                end else if (r_tmo_cnt == TW'(TMO)) begin
                    w_state_nxt   = S_IDLE;
                    w_discard_nxt = 1'b0;
                    w_tmo_hit     = !addr_load;
                end else if (addr_load) begin
                    w_discard_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || r_state != S_WAIT || w_state_nxt != S_WAIT)
            r_tmo_cnt <= '0;
        else
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en      <= 1'b0;
            r_err_tmo <= 1'b0;
            r_cur_adr <= '0;
        end else if (addr_load) begin
            r_en      <= 1'b1;
            r_err_tmo <= 1'b0;
            r_cur_adr <= addr_start;
        end else begin
            if (w_tmo_hit)
                r_err_tmo <= 1'b1;
            if (w_advance)
                r_cur_adr <= next_adr(r_cur_adr, r_start, r_end);
        end
    end

    always_ff @(posedge clk) begin
        if (addr_load) begin
            r_start <= addr_start;
            r_end   <= addr_end;
        end
    end

    // Pop side: a flush cycle suppresses the pop so the pending request survives it.
    assign w_rd_edge = rd_req && !r_rd_req_d;
    assign w_pop     = r_pop_pend && (r_fifo_cnt != '0) && !addr_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_req_d <= 1'b1;
            r_pop_pend <= 1'b0;
            r_rd_ok    <= 1'b0;
        end else begin
            r_rd_req_d <= rd_req;
            r_rd_ok    <= w_pop;
            if (w_pop)
                r_pop_pend <= 1'b0;
            else if (w_rd_edge)
                r_pop_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || addr_load) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)
                r_fifo_cnt <= r_fifo_cnt + CW'(1);
            else if (w_pop && !w_push)
                r_fifo_cnt <= r_fifo_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= sd_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_data_out <= '0;
        else if (w_pop)
            r_data_out <= r_mem[r_rd_ptr];
    end

    assign sd_rd    = (r_state == S_REQ);
    assign sd_adr   = r_cur_adr;
    assign rd_ok    = r_rd_ok;
    assign data_out = r_data_out;
    assign fifo_cnt = r_fifo_cnt;
    assign err_tmo  = r_err_tmo;

endmodule

// File: tb/tb_sdram_rd_prefetch.sv
// Bench for sdram_rd_prefetch: behavioural SDRAM responder plus a queue of expected
// popped words checked on every rd_ok.
module tb_sdram_rd_prefetch;
    localparam int NBIT  = 8;
    localparam int AW    = 22;
    localparam int DEPTH = 4;
    localparam int TMO   = 255;

    logic                   clk = 1'b0;
    logic                   rst, addr_load, rd_req, sd_ack, sd_dv;
    logic [AW-1:0]          addr_start, addr_end, sd_adr;
    logic [NBIT-1:0]        sd_data, data_out;
    logic                   rd_ok, sd_rd, err_tmo;
    logic [$clog2(DEPTH):0] fifo_cnt;

    int checks = 0;
    int errors = 0;
    int n_rdok = 0;
    int dv_dly = 3;
    bit withhold = 1'b0;
    logic [NBIT-1:0] exp_q[$];
    logic [AW-1:0]   req_log[$];
    logic [NBIT-1:0] exp_d;

    always #5 clk = ~clk;

    sdram_rd_prefetch #(.Nbit(NBIT), .AW(AW), .DEPTH(DEPTH), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .addr_load(addr_load), .addr_start(addr_start),
        .addr_end(addr_end), .rd_req(rd_req), .rd_ok(rd_ok), .data_out(data_out),
        .sd_rd(sd_rd), .sd_adr(sd_adr), .sd_ack(sd_ack), .sd_dv(sd_dv),
        .sd_data(sd_data), .fifo_cnt(fifo_cnt), .err_tmo(err_tmo)
    );

    function automatic logic [NBIT-1:0] memf(input logic [AW-1:0] a);
        logic [AW-1:0] t;
        t = a * 7 + 60;
        return t[NBIT-1:0];
    endfunction

    // SDRAM controller model: ack on the first cycle sd_rd is seen, data dv_dly later
    initial begin : sdram_model
        logic [AW-1:0] a;
        sd_ack = 1'b0; sd_dv = 1'b0; sd_data = '0;
        forever begin
            @(negedge clk);
            if (sd_rd === 1'b1) begin
                a = sd_adr;
                req_log.push_back(a);
                sd_ack = 1'b1;
                @(negedge clk);
                sd_ack = 1'b0;
                repeat (dv_dly - 1) @(negedge clk);
                if (!withhold) begin
                    sd_dv = 1'b1; sd_data = memf(a);
                    @(negedge clk);
                    sd_dv = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rd_ok === 1'b1) begin
            n_rdok++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_ok_unexpected: data_out=%h with no word expected", data_out);
            end else begin
                exp_d = exp_q.pop_front();
                if (data_out !== exp_d) begin
                    errors++;
                    $display("FAIL pop_data: got %h expected %h", data_out, exp_d);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic load_window(input logic [AW-1:0] s, input logic [AW-1:0] e);
        addr_load = 1'b1; addr_start = s; addr_end = e;
        @(negedge clk);
        addr_load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_req = 1'b1; addr_load = 1'b0; addr_start = '0; addr_end = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (data_out !== '0 || rd_ok !== 1'b0 || sd_rd !== 1'b0 || sd_adr !== '0 ||
            fifo_cnt !== '0 || err_tmo !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: do=%h ok=%b rd=%b adr=%h cnt=%0d err=%b expected all 0",
                     data_out, rd_ok, sd_rd, sd_adr, fifo_cnt, err_tmo);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (sd_rd !== 1'b0 || req_log.size() != 0) begin
            errors++;
            $display("FAIL prefetch_before_load: sd_rd=%b reqs=%0d expected 0", sd_rd, req_log.size());
        end
    endtask

    task automatic test_fill();
        int k = 0;
        load_window(22'h10, 22'h13);
        while (fifo_cnt !== 3'd4 && k < 100) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        checks++;
        if (fifo_cnt !== 3'd4 || sd_rd !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: cnt=%0d sd_rd=%b expected 4 and 0", fifo_cnt, sd_rd);
        end
        checks++;
        if (req_log.size() != 4) begin
            errors++;
            $display("FAIL fill_reqs: got %0d reads expected 4", req_log.size());
        end
        for (int i = 0; i < 4 && i < req_log.size(); i++) begin
            checks++;
            if (req_log[i] !== AW'(32'h10 + i)) begin
                errors++;
                $display("FAIL fill_adr%0d: got %h expected %h", i, req_log[i], 32'h10 + i);
            end
        end
        checks++;
        if (n_rdok != 0) begin
            errors++;
            $display("FAIL primed_edge: got %0d rd_ok expected 0", n_rdok);
        end
    endtask

    task automatic test_pop_wrap();
        rd_req = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            int lat;
            rd_req = 1'b1;
            exp_q.push_back(memf(AW'(32'h10 + (i % 4))));
            @(negedge clk);
            lat = 1; rd_req = 1'b0;
            while (rd_ok !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
            checks++;
            if (lat != 2) begin
                errors++;
                $display("FAIL pop_latency%0d: got %0d clk expected 2", i, lat);
            end
            @(negedge clk);
            checks++;
            if (rd_ok !== 1'b0) begin
                errors++;
                $display("FAIL pop_single%0d: rd_ok=%b expected 0", i, rd_ok);
            end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_empty_pop();
        int k = 0;
        int base;
        while (fifo_cnt !== 3'd4 && k < 100) begin @(negedge clk); k++; end
        dv_dly = 20;
        load_window(22'h20, 22'h2F);
        rd_req = 1'b1; exp_q.push_back(memf(22'h20));
        @(negedge clk); rd_req = 1'b0;
        repeat (2) @(negedge clk);
        rd_req = 1'b1;
        @(negedge clk); rd_req = 1'b0;
        base = n_rdok;
        k = 0;
        while (fifo_cnt === 3'd0 && rd_ok !== 1'b1 && k < 60) begin @(negedge clk); k++; end
        checks++;
        if (fifo_cnt !== 3'd1 || rd_ok !== 1'b0) begin
            errors++;
            $display("FAIL empty_push: cnt=%0d rd_ok=%b expected 1 and 0", fifo_cnt, rd_ok);
        end
        @(negedge clk);
        checks++;
        if (rd_ok !== 1'b1 || fifo_cnt !== 3'd0) begin
            errors++;
            $display("FAIL empty_pop_lat: rd_ok=%b cnt=%0d expected 1 and 0", rd_ok, fifo_cnt);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (n_rdok - base != 1) begin
            errors++;
            $display("FAIL empty_one_ok: got %0d rd_ok expected 1", n_rdok - base);
        end
    endtask

    task automatic test_timeout();
        int k = 0;
        while (fifo_cnt !== 3'd4 && k < 400) begin @(negedge clk); k++; end
        withhold = 1'b1; dv_dly = 3;
        load_window(22'h30, 22'h33);
        k = 0;
        while (sd_rd !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        checks++;
        if (sd_rd !== 1'b1 || sd_adr !== 22'h30) begin
            errors++;
            $display("FAIL tmo_req: sd_rd=%b adr=%h expected 1 and 000030", sd_rd, sd_adr);
        end
        k = 0;
        while (sd_rd !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        k = 0;
        while (err_tmo !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        checks++;
        if (k != TMO + 1) begin
            errors++;
            $display("FAIL tmo_cycles: err_tmo after %0d WAIT cycles expected %0d", k, TMO + 1);
        end
        withhold = 1'b0;
        k = 0;
        while (sd_rd !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        checks++;
        if (sd_rd !== 1'b1 || sd_adr !== 22'h30) begin
            errors++;
            $display("FAIL tmo_retry: sd_rd=%b adr=%h expected 1 and 000030", sd_rd, sd_adr);
        end
        k = 0;
        while (fifo_cnt !== 3'd1 && k < 30) begin @(negedge clk); k++; end
        checks++;
        if (fifo_cnt !== 3'd1 || err_tmo !== 1'b1) begin
            errors++;
            $display("FAIL tmo_sticky: cnt=%0d err=%b expected 1 and 1", fifo_cnt, err_tmo);
        end
        load_window(22'h30, 22'h33);
        checks++;
        if (err_tmo !== 1'b0 || fifo_cnt !== 3'd0) begin
            errors++;
            $display("FAIL tmo_clear: err=%b cnt=%0d expected 0 and 0", err_tmo, fifo_cnt);
        end
    endtask

    task automatic test_load_in_wait();
        int k = 0;
        dv_dly = 10;
        while (sd_rd !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        k = 0;
        while (sd_rd !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        load_window(22'h40, 22'h43);
        checks++;
        if (fifo_cnt !== 3'd0) begin
            errors++;
            $display("FAIL lw_flush: cnt=%0d expected 0", fifo_cnt);
        end
        k = 0;
        while (sd_rd !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        dv_dly = 3;
        checks++;
        if (k != 10 || sd_adr !== 22'h40 || fifo_cnt !== 3'd0) begin
            errors++;
            $display("FAIL lw_drop: wait=%0d adr=%h cnt=%0d expected 10 000040 0", k, sd_adr, fifo_cnt);
        end
    endtask

    task automatic test_push_pop_same_cycle();
        int k = 0;
        while (!(sd_rd === 1'b1 && fifo_cnt === 3'd2) && k < 80) begin @(negedge clk); k++; end
        @(negedge clk);
        @(negedge clk);
        rd_req = 1'b1; exp_q.push_back(memf(22'h40));
        @(negedge clk);
        rd_req = 1'b0;
        checks++;
        if (fifo_cnt !== 3'd2 || rd_ok !== 1'b0) begin
            errors++;
            $display("FAIL pp_before: cnt=%0d rd_ok=%b expected 2 and 0", fifo_cnt, rd_ok);
        end
        @(negedge clk);
        checks++;
        if (fifo_cnt !== 3'd2 || rd_ok !== 1'b1) begin
            errors++;
            $display("FAIL pp_same_cycle: cnt=%0d rd_ok=%b expected 2 and 1", fifo_cnt, rd_ok);
        end
        repeat (2) @(negedge clk);
        for (int i = 1; i < 3; i++) begin
            int lat;
            rd_req = 1'b1;
            exp_q.push_back(memf(AW'(32'h40 + i)));
            @(negedge clk);
            lat = 1; rd_req = 1'b0;
            while (rd_ok !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
            checks++;
            if (lat != 2) begin
                errors++;
                $display("FAIL pp_order_lat%0d: got %0d clk expected 2", i, lat);
            end
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_pop_wrap();
        test_empty_pop();
        test_timeout();
        test_load_in_wait();
        test_push_pop_same_cycle();
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL words_outstanding: got %0d unpopped expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
